// File: rtl/panda_pulse_pkg.sv
// Shared constants, types and helpers for the panda_pulse delay/stretch stage.
package panda_pulse_pkg;

   localparam int unsigned MIN_DELAY    = 4;
   localparam int unsigned MIN_WIDTH    = 1;
   localparam int unsigned TS_W_DEFAULT = 32;

   typedef logic [TS_W_DEFAULT-1:0] ts_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HIGH = 1'b1
   } pulse_state_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/panda_pulse_fifo.sv
// First-word-fall-through queue of pulse due-times with a synchronous flush.
module panda_pulse_fifo
   import panda_pulse_pkg::*;
#(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned DATA_W = TS_W_DEFAULT,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       count
);

   localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == FullCount);
   assign empty   = (count == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign dout    = mem[rd_ptr];

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + (AW + 1)'(1);
         end else if (do_pop && !do_push) begin
            count <= count - (AW + 1)'(1);
         end
      end
   end

endmodule

// File: rtl/panda_pulse.sv
// Re-emits each rising edge of inp_i as a WIDTH-tick pulse delayed by DELAY ticks,
// dropping and counting edges that overlap the previous pulse or find the queue full.
module panda_pulse
   import panda_pulse_pkg::*;
#(
   parameter int unsigned QUEUE_DEPTH = 256,
   parameter int unsigned TS_W        = TS_W_DEFAULT,
   localparam int unsigned QW         = $clog2(QUEUE_DEPTH) + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            inp_i,
   input  logic [TS_W-1:0] DELAY,
   input  logic [TS_W-1:0] WIDTH,
   input  logic            FORCE_RST,
   output logic            out_o,
   output logic            perr_o,
   output logic [31:0]     MISSED_CNT,
   output logic [QW-1:0]   QUEUE
);

   localparam logic [TS_W-1:0] MinDelay = TS_W'(MIN_DELAY);
   localparam logic [TS_W-1:0] MinWidth = TS_W'(MIN_WIDTH);

   logic [TS_W-1:0] ts_q;
   logic            inp_q;
   logic [TS_W-1:0] delay_q;
   logic [TS_W-1:0] width_q;
   logic [TS_W-1:0] last_ts_q;
   logic            last_valid_q;
   pulse_state_t    state_q, state_d;
   logic [TS_W-1:0] wcnt_q, wcnt_d;
   logic            perr_q;
   logic [31:0]     missed_q;

   logic [TS_W-1:0] d_eff;
   logic [TS_W-1:0] w_eff;
   logic [TS_W-1:0] gap;
   logic [TS_W:0]   w_plus1;
   logic            flush;
   logic            rise;
   logic            no_overlap;
   logic            accept;
   logic            drop;
   logic            pop;
   logic            q_full;
   logic            q_empty;
   logic [TS_W-1:0] head;
   logic [TS_W-1:0] due;

   assign d_eff = (DELAY < MinDelay) ? MinDelay : DELAY;
   assign w_eff = (WIDTH < MinWidth) ? MinWidth : WIDTH;

   assign flush = FORCE_RST | (DELAY != delay_q) | (WIDTH != width_q);
   assign rise  = inp_i & ~inp_q;

   // Gap is taken modulo 2^TS_W; W+1 needs one extra bit so W=max never wraps to 0.
   assign gap        = ts_q - last_ts_q;
   assign w_plus1    = {1'b0, w_eff} + (TS_W + 1)'(1);
   assign no_overlap = ~last_valid_q | ({1'b0, gap} >= w_plus1);

   assign accept = rise & ~flush & ~q_full & no_overlap;
   assign drop   = rise & ~flush & ~accept;
   assign due    = ts_q + d_eff;

   panda_pulse_fifo #(
      .DEPTH  (QUEUE_DEPTH),
      .DATA_W (TS_W)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (accept),
      .pop   (pop),
      .flush (flush),
      .din   (due),
      .dout  (head),
      .full  (q_full),
      .empty (q_empty),
      .count (QUEUE)
   );

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      pop     = 1'b0;
      if (flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (!q_empty && (head == ts_q)) begin
                  pop     = 1'b1;
                  state_d = HIGH;
                  wcnt_d  = w_eff - TS_W'(1);
               end
            end
            HIGH: begin
               if (wcnt_q == '0) begin
                  state_d = IDLE;
               end else begin
                  wcnt_d = wcnt_q - TS_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Not reset on purpose: reset must never look like a DELAY/WIDTH change.
   always_ff @(posedge clk_i) begin
      delay_q <= DELAY;
      width_q <= WIDTH;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ts_q         <= '0;
         inp_q        <= 1'b0;
         last_ts_q    <= '0;
         last_valid_q <= 1'b0;
         state_q      <= IDLE;
         wcnt_q       <= '0;
         perr_q       <= 1'b0;
         missed_q     <= '0;
      end else begin
         ts_q    <= ts_q + TS_W'(1);
         inp_q   <= inp_i;
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         perr_q  <= drop;
         if (FORCE_RST) begin
            missed_q <= '0;
         end else if (drop) begin
            missed_q <= sat_inc32(missed_q);
         end
         if (flush) begin
            last_valid_q <= 1'b0;
         end else if (accept) begin
            last_ts_q    <= ts_q;
            last_valid_q <= 1'b1;
         end
      end
   end

   assign out_o      = (state_q == HIGH);
   assign perr_o     = perr_q;
   assign MISSED_CNT = missed_q;

endmodule
